// File: rtl/image_unpack.sv
// image_unpack: converts UDP payload words into a registered RGB565 pixel stream with x/y position.
// Ports: sys_clk, sys_rst (async, active high); rec_en/rec_data/rec_pkt_done/rec_byte_num from the UDP receiver;
//   pix_valid/pix_data/pix_x/pix_y pixel stream; line_done, frame_done, pkt_err single-cycle pulses.
// Option: define IMG_UNPACK_HDR_CHECK_EN to reject frame-start headers other than 32'h5AA5_F00F.
module image_unpack #(
  parameter int H_PIX      = 1280,
  parameter int V_LINES    = 720,
  parameter int LINE_BYTES = 2560,
  parameter int SOF_BYTES  = 2564
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rec_en,
  input  logic [31:0] rec_data,
  input  logic        rec_pkt_done,
  input  logic [15:0] rec_byte_num,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        line_done,
  output logic        frame_done,
  output logic        pkt_err
);

  localparam logic [15:0] LINE_B = 16'(LINE_BYTES);
  localparam logic [15:0] SOF_B  = 16'(SOF_BYTES);
  localparam logic [15:0] HALF   = 16'(H_PIX / 2);
  localparam logic [10:0] X_LAST = 11'(H_PIX - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_LINES - 1);

  typedef enum logic [1:0] {WAIT_SOF, HDR, LINE, DROP} state_t;

  state_t      state;
  logic [10:0] col;        // column of the next pixel to emit
  logic [9:0]  row;        // line of the next pixel to emit
  logic [15:0] word_cnt;   // words seen in the current packet, header included
  logic        has_hdr;    // current packet carried a frame-start header
  logic        pkt_start;  // next rec_en is the first word of a packet
  logic        pend;       // upper half-word waiting to be emitted
  logic [15:0] pend_dat;
`ifdef IMG_UNPACK_HDR_CHECK_EN
  localparam logic [31:0] HDR_MAGIC = 32'h5AA5_F00F;
  logic [31:0] hdr_word;
`endif

  logic        is_hdr_word, take_word, overrun, emit, abort, end_bad, hdr_nxt;
  logic [15:0] emit_dat, cnt_nxt, data_words, exp_words, data_idx;

  always_comb begin
    is_hdr_word = rec_en && !pend && (rec_byte_num == SOF_B) &&
                  ((state == WAIT_SOF) || (state == LINE && pkt_start));
    data_idx    = word_cnt - {15'd0, has_hdr};
    // A word arriving while the upper half is still queued (or right behind a header) is lost.
    overrun     = rec_en && (pend || state == HDR);
    take_word   = rec_en && !overrun && !is_hdr_word && (state == LINE) && (data_idx < HALF);
    emit        = pend || take_word;
    emit_dat    = pend ? pend_dat : rec_data[15:0];
    // Packet-end checks include a word arriving in the same cycle as rec_pkt_done.
    cnt_nxt     = word_cnt + {15'd0, rec_en};
    hdr_nxt     = has_hdr | is_hdr_word;
    data_words  = cnt_nxt - {15'd0, hdr_nxt};
    exp_words   = (rec_byte_num - (hdr_nxt ? 16'd4 : 16'd0)) >> 2;
    end_bad     = (data_words != exp_words) || ((rec_byte_num != LINE_B) && (rec_byte_num != SOF_B));
    abort       = rec_pkt_done && (state == LINE || state == HDR) && end_bad;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= WAIT_SOF;
      col        <= '0;
      row        <= '0;
      word_cnt   <= '0;
      has_hdr    <= 1'b0;
      pkt_start  <= 1'b1;
      pend       <= 1'b0;
      pend_dat   <= '0;
`ifdef IMG_UNPACK_HDR_CHECK_EN
      hdr_word   <= '0;
`endif
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      pkt_err    <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      pkt_err    <= overrun;
      word_cnt   <= cnt_nxt;
      if (rec_en) pkt_start <= 1'b0;

      pend <= take_word;
      if (take_word) pend_dat <= rec_data[31:16];

      if (emit) begin
        pix_valid <= 1'b1;
        pix_data  <= emit_dat;
        pix_x     <= col;
        pix_y     <= row;
        if (col == X_LAST) begin
          col       <= '0;
          line_done <= 1'b1;
          if (row == Y_LAST) begin
            row        <= '0;
            frame_done <= 1'b1;
            state      <= WAIT_SOF;
          end else begin
            row <= row + 10'd1;
          end
        end else begin
          col <= col + 11'd1;
        end
      end

      case (state)
        WAIT_SOF: if (rec_en && !is_hdr_word && !rec_pkt_done) state <= DROP;
        HDR: begin
`ifdef IMG_UNPACK_HDR_CHECK_EN
          if (hdr_word != HDR_MAGIC) begin
            pkt_err <= 1'b1;
            state   <= DROP;
          end else begin
            state <= LINE;
          end
`else
          state <= LINE;
`endif
        end
        DROP: if (rec_pkt_done) state <= WAIT_SOF;
        default: ;
      endcase

      // Frame-start header, either opening a frame or resynchronising one in progress.
      if (is_hdr_word) begin
        state    <= HDR;
        has_hdr  <= 1'b1;
        word_cnt <= 16'd1;
        col      <= '0;
        row      <= '0;
        pix_x    <= '0;
        pix_y    <= '0;
`ifdef IMG_UNPACK_HDR_CHECK_EN
        hdr_word <= rec_data;
`endif
      end

      // Bad packet: rewind to column 0 on the same line so the next packet retries it.
      if (abort) begin
        pkt_err    <= 1'b1;
        col        <= '0;
        pix_x      <= '0;
        pend       <= 1'b0;
        pix_valid  <= 1'b0;
        line_done  <= 1'b0;
        frame_done <= 1'b0;
      end

      if (rec_pkt_done) begin
        word_cnt  <= '0;
        has_hdr   <= 1'b0;
        pkt_start <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_image_unpack.sv
module tb_image_unpack;
  localparam int H = 8, V = 4, LB = 16, SB = 20;
  localparam int HALF = H / 2;
  localparam logic [31:0] MAGIC = 32'h5AA5_F00F;
`ifdef IMG_UNPACK_HDR_CHECK_EN
  localparam bit HDR_CHECK = 1'b1;
`else
  localparam bit HDR_CHECK = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        rec_en = 1'b0;
  logic [31:0] rec_data = '0;
  logic        rec_pkt_done = 1'b0;
  logic [15:0] rec_byte_num = '0;
  logic        pix_valid, line_done, frame_done, pkt_err;
  logic [15:0] pix_data;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;

  image_unpack #(.H_PIX(H), .V_LINES(V), .LINE_BYTES(LB), .SOF_BYTES(SB)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rec_en(rec_en), .rec_data(rec_data),
    .rec_pkt_done(rec_pkt_done), .rec_byte_num(rec_byte_num), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .line_done(line_done),
    .frame_done(frame_done), .pkt_err(pkt_err));

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    int          cyc;
    logic [15:0] dat;
    logic [10:0] x;
    logic [9:0]  y;
    logic        ld;
    logic        fd;
  } pix_t;

  int   cyc = 0;
  int   n_checks = 0, n_fail = 0;
  int   err_seen = 0, last_err_cyc = -1, stray = 0;
  pix_t obs_q[$], exp_q[$];
  int   p_cyc[$];
  logic [31:0] p_dat[$];
  int   p_done;
  // Reference model: position of the next pixel and whether a frame is open.
  int   m_x = 0, m_y = 0;
  bit   m_in_frame = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (pix_valid) obs_q.push_back('{cyc, pix_data, pix_x, pix_y, line_done, frame_done});
      else if (line_done || frame_done) stray++;
      if (pkt_err) begin
        err_seen++;
        last_err_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_pkt(input int nbytes, input int nwords, input logic [31:0] hdr,
                          input int ov, input bit with_done);
    p_cyc.delete();
    p_dat.delete();
    rec_byte_num = 16'(nbytes);
    for (int i = 0; i < nwords; i++) begin
      if (i > 0 && i != ov) begin
        tick();
        if ($urandom_range(0, 3) == 0) tick();
      end
      rec_en   = 1'b1;
      rec_data = (i == 0 && nbytes == SB) ? hdr : $urandom();
      p_cyc.push_back(cyc);
      p_dat.push_back(rec_data);
      tick();
      rec_en = 1'b0;
    end
    if (with_done) begin
      tick();
      rec_pkt_done = 1'b1;
      p_done = cyc;
      tick();
      rec_pkt_done = 1'b0;
    end
    repeat (3) tick();
  endtask

  task automatic m_emit(input logic [15:0] d, input int c);
    pix_t r;
    r.cyc = c;
    r.dat = d;
    r.x   = 11'(m_x);
    r.y   = 10'(m_y);
    r.ld  = (m_x == H - 1);
    r.fd  = (m_x == H - 1) && (m_y == V - 1);
    exp_q.push_back(r);
    m_x++;
    if (m_x == H) begin
      m_x = 0;
      m_y++;
      if (m_y == V) begin
        m_y = 0;
        m_in_frame = 1'b0;
      end
    end
  endtask

  task automatic model_pkt(input int nbytes, input int ov, input bit with_done,
                           output int exp_err, output bit done_err);
    int first;
    bit prev_emit;
    first = 0;
    prev_emit = 1'b0;
    exp_err = 0;
    done_err = 1'b0;
    if (!m_in_frame && nbytes != SB) return;
    if (nbytes == SB) begin
      first = 1;
      if (HDR_CHECK && p_dat[0] != MAGIC) begin
        exp_err = 1;
        m_in_frame = 1'b0;
        return;
      end
      m_in_frame = 1'b1;
      m_x = 0;
      m_y = 0;
    end
    for (int i = first; i < p_cyc.size(); i++) begin
      if (i == ov && prev_emit) begin
        exp_err++;
        prev_emit = 1'b0;
        continue;
      end
      prev_emit = 1'b0;
      if (!m_in_frame || (i - first) >= HALF) continue;
      m_emit(p_dat[i][15:0], p_cyc[i] + 1);
      m_emit(p_dat[i][31:16], p_cyc[i] + 2);
      prev_emit = 1'b1;
    end
    if (with_done && m_in_frame) begin
      if ((p_cyc.size() - first) != (nbytes - 4 * first) / 4 || (nbytes != LB && nbytes != SB)) begin
        exp_err++;
        done_err = 1'b1;
        m_x = 0;
      end
    end
  endtask

  task automatic compare(input string tag);
    pix_t o, e;
    check({tag, "_npix"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_pix"}, {o.ld, o.fd, o.y, o.x, o.dat}, {e.ld, e.fd, e.y, e.x, e.dat});
      check({tag, "_cyc"}, 64'(o.cyc), 64'(e.cyc));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run(input int nbytes, input int nwords, input logic [31:0] hdr, input int ov,
                     input string tag);
    int e0, exp_err;
    bit done_err;
    e0 = err_seen;
    send_pkt(nbytes, nwords, hdr, ov, 1'b1);
    model_pkt(nbytes, ov, 1'b1, exp_err, done_err);
    compare(tag);
    check({tag, "_errs"}, 64'(err_seen - e0), 64'(exp_err));
    if (done_err) begin
      check({tag, "_err_cyc"}, 64'(last_err_cyc), 64'(p_done + 1));
      check({tag, "_x0"}, 64'(pix_x), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] w;
    int c, e0;
    repeat (3) tick();
    check("reset_out", {pix_valid, pix_data, pix_x, pix_y, line_done, frame_done, pkt_err}, 64'd0);
    sys_rst = 1'b0;
    tick();

    run(LB, HALF, MAGIC, -1, "line_no_sof");
    run(SB, HALF + 1, MAGIC, -1, "sof");
    for (int v = 1; v < V; v++) run(LB, HALF, MAGIC, -1, "frame_line");
    run(SB, HALF + 1, MAGIC, -1, "sof_b");
    run(LB - 4, HALF - 1, MAGIC, -1, "short");
    run(LB, HALF, MAGIC, -1, "retry");
    run(LB, HALF, MAGIC, 2, "overrun");
    run(LB, HALF + 2, MAGIC, -1, "long");
    run(SB, HALF + 1, MAGIC, -1, "resync");

    // Reset while the upper half of a word is still queued.
    e0 = err_seen;
    rec_byte_num = 16'(LB);
    w = $urandom();
    rec_en = 1'b1;
    rec_data = w;
    c = cyc;
    tick();
    rec_en = 1'b0;
    @(negedge sys_clk);
    #1;
    sys_rst = 1'b1;
    #1;
    m_emit(w[15:0], c + 1);
    m_x = 0;
    m_y = 0;
    m_in_frame = 1'b0;
    check("rst_mid_out", {pix_valid, pix_data, pix_x, pix_y, line_done, frame_done, pkt_err}, 64'd0);
    tick();
    check("rst_hold_out", {pix_valid, pix_data, pix_x, pix_y, line_done, frame_done, pkt_err}, 64'd0);
    sys_rst = 1'b0;
    repeat (3) tick();
    compare("rst_mid");
    check("rst_mid_errs", 64'(err_seen - e0), 64'd0);

    run(SB, HALF + 1, 32'h0, -1, "hdr_zero");
    run(SB, HALF + 1, MAGIC, -1, "sof_after");

    for (int it = 0; it < 80; it++) begin
      if (!m_in_frame) begin
        run(SB, HALF + 1, ($urandom_range(0, 3) == 0) ? $urandom() : MAGIC, -1, "r_sof");
      end else begin
        case ($urandom_range(0, 9))
          0: run(LB - 4, HALF - 1, MAGIC, -1, "r_short");
          1: run(LB, HALF, MAGIC, $urandom_range(1, HALF - 1), "r_ovr");
          2: run(LB, HALF + 1, MAGIC, -1, "r_long");
          3: run(SB, HALF + 1, MAGIC, -1, "r_resync");
          default: run(LB, HALF, MAGIC, -1, "r_line");
        endcase
      end
    end
    check("stray_pulses", 64'(stray), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end
endmodule
